// File: rtl/centroid_x_calc.sv
// Horizontal centroid of above-threshold pixels in a raster stream.
// Per-frame x-sum and hit count feed a 32-cycle restoring divider.
module centroid_x_calc #(
    parameter int DATA_W     = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int THRESHOLD  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pixel_valid,
    input  logic [DATA_W-1:0] pixel,
    input  logic              sop,
    input  logic              eop,
    output logic [10:0]       value,
    output logic              ready,
    output logic              busy,
    output logic              overrun
);
    localparam logic [0:0]        IDLE      = 1'b0;
    localparam logic [0:0]        DIV       = 1'b1;
    localparam logic [10:0]       X_LAST    = 11'(IMG_WIDTH - 1);
    localparam logic [DATA_W-1:0] THR       = DATA_W'(THRESHOLD);
    localparam logic [19:0]       COUNT_MAX = 20'(IMG_WIDTH * IMG_HEIGHT);
    localparam logic [31:0]       Q_MAX     = 32'd2047;

    logic [10:0] x_r;
    logic [31:0] sum_r;
    logic [19:0] count_r;
    logic [0:0]  state_r;
    logic [4:0]  iter_r;
    logic [31:0] dvd_r;
    logic [19:0] dvs_r;
    logic [19:0] rem_r;
    logic        dvs_zero_r;

    logic [10:0] cur_x_s;
    logic [10:0] x_next_s;
    logic        hit_s;
    logic [31:0] sum_base_s;
    logic [19:0] count_base_s;
    logic [31:0] sum_next_s;
    logic [19:0] count_next_s;
    logic [20:0] rem_sh_s;
    logic [20:0] diff_s;
    logic        q_bit_s;
    logic [19:0] rem_next_s;
    logic [31:0] quot_s;

    // Accumulator next-state for the current beat; sop restarts the frame.
    always_comb begin
        cur_x_s      = sop ? 11'd0 : x_r;
        hit_s        = (pixel >= THR);
        sum_base_s   = sop ? 32'd0 : sum_r;
        count_base_s = sop ? 20'd0 : count_r;
        x_next_s     = (cur_x_s >= X_LAST) ? 11'd0 : cur_x_s + 11'd1;
        if (hit_s) begin
            sum_next_s   = sum_base_s + {21'd0, cur_x_s};
            // Saturating guard keeps a malformed stream without eop from wrapping
            count_next_s = (count_base_s < COUNT_MAX) ? count_base_s + 20'd1 : count_base_s;
        end else begin
            sum_next_s   = sum_base_s;
            count_next_s = count_base_s;
        end
    end

    // One restoring-division step: remainder never exceeds the divisor, so bit 20 of diff is the borrow.
    always_comb begin
        rem_sh_s   = {rem_r, dvd_r[31]};
        diff_s     = rem_sh_s - {1'b0, dvs_r};
        q_bit_s    = ~diff_s[20];
        rem_next_s = q_bit_s ? diff_s[19:0] : rem_sh_s[19:0];
        quot_s     = {dvd_r[30:0], q_bit_s};
    end

    // X position and per-frame accumulators; eop empties them for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r     <= 11'd0;
            sum_r   <= 32'd0;
            count_r <= 20'd0;
        end else if (pixel_valid) begin
            if (eop) begin
                x_r     <= 11'd0;
                sum_r   <= 32'd0;
                count_r <= 20'd0;
            end else begin
                x_r     <= x_next_s;
                sum_r   <= sum_next_s;
                count_r <= count_next_s;
            end
        end
    end

    // Divider FSM, result register and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            iter_r     <= 5'd0;
            dvd_r      <= 32'd0;
            dvs_r      <= 20'd0;
            rem_r      <= 20'd0;
            dvs_zero_r <= 1'b0;
            value      <= 11'd0;
            ready      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            ready   <= 1'b0;
            overrun <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pixel_valid && eop) begin
                        state_r    <= DIV;
                        iter_r     <= 5'd0;
                        dvd_r      <= sum_next_s;
                        dvs_r      <= count_next_s;
                        rem_r      <= 20'd0;
                        dvs_zero_r <= (count_next_s == 20'd0);
                    end
                end
                DIV: begin
                    if (pixel_valid && eop) begin
                        overrun <= 1'b1;
                    end
                    rem_r  <= rem_next_s;
                    dvd_r  <= quot_s;
                    iter_r <= iter_r + 5'd1;
                    if (iter_r == 5'd31) begin
                        state_r <= IDLE;
                        ready   <= 1'b1;
                        if (dvs_zero_r) begin
                            value <= 11'd0;
                        end else if (quot_s > Q_MAX) begin
                            value <= 11'd2047;
                        end else begin
                            value <= quot_s[10:0];
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_r == DIV);

endmodule

// File: tb/tb_centroid_x_calc.sv
// Bench for centroid_x_calc: vector table, corner sequences and random frames
// checked cycle by cycle against a frame-level reference model.
module tb_centroid_x_calc;
    localparam int W   = 16;
    localparam int H   = 4;
    localparam int THR = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [7:0]  pixel = 8'd0;
    logic        sop = 1'b0;
    logic        eop = 1'b0;
    logic [10:0] value;
    logic        ready;
    logic        busy;
    logic        overrun;

    int n_cmp = 0;
    int n_bad = 0;

    centroid_x_calc #(.DATA_W(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(THR)) dut (
        .clk(clk), .rst_n(rst_n), .pixel_valid(pixel_valid), .pixel(pixel),
        .sop(sop), .eop(eop), .value(value), .ready(ready), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Reference model: collects hit x positions per frame, divides at eop.
    int          cyc = 0;
    int          mx = 0;
    int          done_edge = -1;
    int          ovr_edge = -1;
    int          hits[$];
    logic [10:0] pend_value = 11'd0;
    logic [10:0] exp_value = 11'd0;
    logic        exp_ready = 1'b0;
    logic        exp_busy = 1'b0;
    logic        exp_ovr = 1'b0;
    bit          chk_en = 1'b0;

    function automatic logic [10:0] centroid(input int q[$]);
        longint s;
        s = 0;
        foreach (q[i]) s += q[i];
        if (q.size() == 0) return 11'd0;
        s = s / q.size();
        if (s > 2047) return 11'd2047;
        return 11'(s);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mx = 0;
            hits.delete();
            done_edge = -1;
            ovr_edge = -1;
            exp_value = 11'd0;
            exp_ready = 1'b0;
            exp_busy = 1'b0;
            exp_ovr = 1'b0;
        end else begin
            cyc++;
            if (pixel_valid) begin
                int cx;
                cx = sop ? 0 : mx;
                if (sop) hits.delete();
                if (int'(pixel) >= THR) hits.push_back(cx);
                if (eop) begin
                    if (cyc <= done_edge) ovr_edge = cyc;
                    else begin
                        done_edge = cyc + 32;
                        pend_value = centroid(hits);
                    end
                    hits.delete();
                    mx = 0;
                end else begin
                    mx = (cx == W - 1) ? 0 : cx + 1;
                end
            end
            if (cyc == done_edge) exp_value = pend_value;
            exp_ready = (cyc == done_edge);
            exp_busy  = (cyc < done_edge);
            exp_ovr   = (cyc == ovr_edge);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if ({value, ready, busy, overrun} !== {exp_value, exp_ready, exp_busy, exp_ovr}) begin
                n_bad++;
                $display("FAIL cycle_check t=%0t got value=%0d ready=%b busy=%b overrun=%b, want value=%0d ready=%b busy=%b overrun=%b",
                         $time, value, ready, busy, overrun, exp_value, exp_ready, exp_busy, exp_ovr);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic send_frame(input int nb, input int h0, input int h1, input int h2,
                              input logic [7:0] hp, input logic [7:0] bg, input int gap);
        for (int b = 0; b < nb; b++) begin
            if (gap > 0 && b > 0 && (b % gap) == 0) begin
                pixel_valid = 1'b0;
                pixel = 8'($urandom);
                sop = 1'($urandom);
                eop = 1'($urandom);
                @(negedge clk);
            end
            pixel_valid = 1'b1;
            sop = (b == 0);
            eop = (b == nb - 1);
            pixel = (b == h0 || b == h1 || b == h2) ? hp : bg;
            @(negedge clk);
        end
        pixel_valid = 1'b0;
        sop = 1'b0;
        eop = 1'b0;
        pixel = 8'd0;
    endtask

    // Called right after the eop beat; ready must land 32 edges after the eop edge.
    task automatic measure(input string tag, input logic [10:0] expv);
        int busy_n;
        int rdy_n;
        int rdy_at;
        busy_n = 0;
        rdy_n = 0;
        rdy_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_n++;
            if (ready) begin
                rdy_n++;
                if (rdy_at < 0) rdy_at = i;
            end
            @(negedge clk);
        end
        check({tag, "_ready_at"}, 32'(rdy_at), 32'd32);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd32);
        check({tag, "_ready_pulses"}, 32'(rdy_n), 32'd1);
        check({tag, "_value"}, 32'(value), 32'(expv));
    endtask

    typedef struct {
        int          nb;
        int          h0;
        int          h1;
        int          h2;
        logic [7:0]  hp;
        logic [7:0]  bg;
        int          gap;
        logic [10:0] expv;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int   ov;
        int   rd;
        int   nb;
        int   gap;

        tbl[0] = '{16, 4, 8, -1, 8'd200, 8'd0, 0, 11'd6};
        tbl[1] = '{64, 3, 42, 58, 8'd200, 8'd0, 5, 11'd7};
        tbl[2] = '{16, 5, -1, -1, 8'd128, 8'd0, 0, 11'd5};
        tbl[3] = '{16, -1, -1, -1, 8'd200, 8'd127, 3, 11'd0};
        tbl[4] = '{16, 15, -1, -1, 8'd255, 8'd0, 0, 11'd15};
        tbl[5] = '{32, 20, -1, -1, 8'd200, 8'd127, 4, 11'd4};
        tbl[6] = '{1, 0, -1, -1, 8'd200, 8'd0, 0, 11'd0};

        // Reset held with inputs toggling
        for (int i = 0; i < 9; i++) begin
            if (i == 3) chk_en = 1'b1;
            pixel_valid = 1'($urandom);
            pixel = 8'($urandom);
            sop = 1'($urandom);
            eop = 1'($urandom);
            @(negedge clk);
        end
        pixel_valid = 1'b0;
        sop = 1'b0;
        eop = 1'b0;
        pixel = 8'd0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int t = 0; t < 7; t++) begin
            send_frame(tbl[t].nb, tbl[t].h0, tbl[t].h1, tbl[t].h2, tbl[t].hp, tbl[t].bg, tbl[t].gap);
            measure($sformatf("vec%0d", t), tbl[t].expv);
        end

        // Back-to-back: next frame starts the cycle after eop, its eop lands after the divider is free
        send_frame(16, -1, -1, -1, 8'd0, 8'd127, 0);
        send_frame(48, 15, -1, -1, 8'd200, 8'd0, 0);
        measure("b2b", 11'd15);

        // Overrun: one-pixel frame arrives 5 cycles after the previous eop
        send_frame(16, 2, -1, -1, 8'd200, 8'd0, 0);
        ov = 0;
        rd = 0;
        for (int i = 0; i < 45; i++) begin
            if (overrun) ov++;
            if (ready) rd++;
            if (i == 4) begin
                pixel_valid = 1'b1;
                sop = 1'b1;
                eop = 1'b1;
                pixel = 8'd200;
            end else begin
                pixel_valid = 1'b0;
                sop = 1'b0;
                eop = 1'b0;
                pixel = 8'd0;
            end
            @(negedge clk);
        end
        check("ovr_overrun_pulses", 32'(ov), 32'd1);
        check("ovr_ready_pulses", 32'(rd), 32'd1);
        check("ovr_value", 32'(value), 32'd2);

        // Asynchronous reset ten cycles into a division
        send_frame(16, 6, -1, -1, 8'd200, 8'd0, 0);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_ready", 32'(ready), 32'd0);
        check("async_rst_overrun", 32'(overrun), 32'd0);
        check("async_rst_value", 32'(value), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready) rd++;
            @(negedge clk);
        end
        check("abort_ready_pulses", 32'(rd), 32'd0);
        check("abort_value", 32'(value), 32'd0);
        send_frame(16, 9, -1, -1, 8'd200, 8'd0, 0);
        measure("after_rst", 11'd9);

        // Random frames with random spacing; some overlap the divider
        for (int r = 0; r < 30; r++) begin
            nb = $urandom_range(1, 64);
            gap = $urandom_range(0, 6);
            for (int b = 0; b < nb; b++) begin
                if (gap > 0 && b > 0 && (b % gap) == 0) begin
                    pixel_valid = 1'b0;
                    pixel = 8'($urandom);
                    sop = 1'($urandom);
                    eop = 1'($urandom);
                    @(negedge clk);
                end
                pixel_valid = 1'b1;
                sop = (b == 0);
                eop = (b == nb - 1);
                pixel = 8'($urandom);
                @(negedge clk);
            end
            pixel_valid = 1'b0;
            sop = 1'b0;
            eop = 1'b0;
            repeat ($urandom_range(0, 45)) @(negedge clk);
        end
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
